// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode constants, FSM state encoding and IR field positions for control_sequencer.
// Optional MUL/DIV support is enabled in the design files with `define CTRL_SEQ_MULDIV_EN.
package cpu_ctrl_pkg;

  localparam int OPC_W = 5;
  localparam int RIDX_W = 4;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RA_HI  = 26;
  localparam int RA_LO  = 23;
  localparam int RB_HI  = 22;
  localparam int RB_LO  = 19;
  localparam int RC_HI  = 18;
  localparam int RC_LO  = 15;

  localparam logic [OPC_W-1:0] OP_ADD = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB = 5'b00100;
  localparam logic [OPC_W-1:0] OP_SHR = 5'b00101;
  localparam logic [OPC_W-1:0] OP_SHL = 5'b00110;
  localparam logic [OPC_W-1:0] OP_ROR = 5'b00111;
  localparam logic [OPC_W-1:0] OP_ROL = 5'b01000;
  localparam logic [OPC_W-1:0] OP_AND = 5'b01001;
  localparam logic [OPC_W-1:0] OP_OR  = 5'b01010;
  localparam logic [OPC_W-1:0] OP_MUL = 5'b01110;
  localparam logic [OPC_W-1:0] OP_DIV = 5'b01111;
  localparam logic [OPC_W-1:0] OP_NEG = 5'b10000;
  localparam logic [OPC_W-1:0] OP_NOT = 5'b10001;
  localparam logic [OPC_W-1:0] OP_INC = 5'b11111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    T3   = 3'd4,
    T4   = 3'd5,
    T5   = 3'd6,
    T6   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    CLS_ILLEGAL = 2'd0,
    CLS_UNARY   = 2'd1,
    CLS_BINARY  = 2'd2,
    CLS_MULDIV  = 2'd3
  } op_class_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: IR -> operation class, ALU op and register fields.
// MUL/DIV are recognised only when CTRL_SEQ_MULDIV_EN is defined; otherwise they decode as illegal.
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic [DATA_W-1:0] ir,
  output op_class_t         op_class,
  output logic [OPC_W-1:0]  alu_op,
  output logic [RIDX_W-1:0] ra,
  output logic [RIDX_W-1:0] rb,
  output logic [RIDX_W-1:0] rc
);

  logic [OPC_W-1:0] opc_s;
  op_class_t        cls_s;
  logic             range_bad_s;
  logic             unused_ir_bits;

  assign opc_s = ir[OPC_HI:OPC_LO];
  assign ra    = ir[RA_HI:RA_LO];
  assign rb    = ir[RB_HI:RB_LO];
  assign rc    = ir[RC_HI:RC_LO];
  assign unused_ir_bits = ^ir[RC_LO-1:0];

  // Opcode classification; Rc only matters for two-operand forms.
  always_comb begin
    cls_s = CLS_ILLEGAL;
    case (opc_s)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:  cls_s = CLS_BINARY;
      OP_NEG, OP_NOT:                 cls_s = CLS_UNARY;
`ifdef CTRL_SEQ_MULDIV_EN
      OP_MUL, OP_DIV:                 cls_s = CLS_MULDIV;
`endif
      default:                        cls_s = CLS_ILLEGAL;
    endcase
  end

  // Register fields wider than the register file force an illegal decode.
  always_comb begin
    range_bad_s = 1'b0;
    if ((int'(ra) >= NUM_REGS) || (int'(rb) >= NUM_REGS)) begin
      range_bad_s = 1'b1;
    end else if ((cls_s != CLS_UNARY) && (int'(rc) >= NUM_REGS)) begin
      range_bad_s = 1'b1;
    end else begin
      range_bad_s = 1'b0;
    end
  end

  // Final class and ALU op; illegal instructions never carry an ALU op.
  always_comb begin
    if (range_bad_s || (cls_s == CLS_ILLEGAL)) begin
      op_class = CLS_ILLEGAL;
      alu_op   = '0;
    end else begin
      op_class = cls_s;
      alu_op   = opc_s;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute step sequencer for the 32-bit datapath (T0..T5, T6 for MUL/DIV).
// Define CTRL_SEQ_MULDIV_EN to build the MUL/DIV path (LO/HI loads and state T6).
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int OP_W     = 5
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic                mem_rdy,
  input  logic [DATA_W-1:0]   ir_in,
  output logic                pc_out,
  output logic                mdr_out,
  output logic                zlow_out,
  output logic                zhigh_out,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_in,
  output logic                mar_in,
  output logic                pc_in,
  output logic                mdr_in,
  output logic                ir_in_en,
  output logic                y_in,
  output logic                z_in,
  output logic                inc_pc,
  output logic                read,
  output logic                lo_in,
  output logic                hi_in,
  output logic [OP_W-1:0]     alu_op,
  output logic                busy,
  output logic                done,
  output logic                illegal_op
);

  localparam logic [NUM_REGS-1:0] ONE_HOT0 = NUM_REGS'(1);

  state_t            state_r;
  logic              t1_first_r;
  op_class_t         cls_r;
  logic [OPC_W-1:0]  alu_r;
  logic [RIDX_W-1:0] ra_r;
  logic [RIDX_W-1:0] rc_r;

  op_class_t         dec_class_s;
  logic [OPC_W-1:0]  dec_alu_s;
  logic [RIDX_W-1:0] dec_ra_s;
  logic [RIDX_W-1:0] dec_rb_s;
  logic [RIDX_W-1:0] dec_rc_s;

  ctrl_decode #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_decode (
    .ir       (ir_in),
    .op_class (dec_class_s),
    .alu_op   (dec_alu_s),
    .ra       (dec_ra_s),
    .rb       (dec_rb_s),
    .rc       (dec_rc_s)
  );

  // State sequencing; the decode is captured in T3 because IR only becomes valid there.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r    <= IDLE;
      t1_first_r <= 1'b0;
      cls_r      <= CLS_ILLEGAL;
      alu_r      <= '0;
      ra_r       <= '0;
      rc_r       <= '0;
    end else begin
      case (state_r)
        IDLE: if (start) state_r <= T0;
        T0: begin
          state_r    <= T1;
          t1_first_r <= 1'b1;
        end
        T1: begin
          t1_first_r <= 1'b0;
          if (mem_rdy) state_r <= T2;
        end
        T2: state_r <= T3;
        T3: begin
          cls_r <= dec_class_s;
          alu_r <= dec_alu_s;
          ra_r  <= dec_ra_s;
          rc_r  <= dec_rc_s;
          case (dec_class_s)
            CLS_UNARY:             state_r <= T5;
            CLS_BINARY, CLS_MULDIV: state_r <= T4;
            default:               state_r <= IDLE;
          endcase
        end
        T4: state_r <= T5;
`ifdef CTRL_SEQ_MULDIV_EN
        T5: state_r <= (cls_r == CLS_MULDIV) ? T6 : IDLE;
        T6: state_r <= IDLE;
`else
        T5: state_r <= IDLE;
`endif
        default: state_r <= IDLE;
      endcase
    end
  end

  // Control decode of the current step; T3 looks at the live IR decode.
  always_comb begin
    pc_out     = 1'b0;
    mdr_out    = 1'b0;
    zlow_out   = 1'b0;
    zhigh_out  = 1'b0;
    reg_out    = '0;
    reg_in     = '0;
    mar_in     = 1'b0;
    pc_in      = 1'b0;
    mdr_in     = 1'b0;
    ir_in_en   = 1'b0;
    y_in       = 1'b0;
    z_in       = 1'b0;
    inc_pc     = 1'b0;
    read       = 1'b0;
    lo_in      = 1'b0;
    hi_in      = 1'b0;
    alu_op     = '0;
    busy       = (state_r != IDLE);
    done       = 1'b0;
    illegal_op = 1'b0;
    case (state_r)
      T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
        alu_op = OP_W'(OP_INC);
      end
      T1: begin
        read     = 1'b1;
        mdr_in   = 1'b1;
        zlow_out = t1_first_r;
        pc_in    = t1_first_r;
      end
      T2: begin
        mdr_out  = 1'b1;
        ir_in_en = 1'b1;
      end
      T3: begin
        case (dec_class_s)
          CLS_UNARY: begin
            reg_out = ONE_HOT0 << dec_rb_s;
            z_in    = 1'b1;
            alu_op  = OP_W'(dec_alu_s);
          end
          CLS_BINARY, CLS_MULDIV: begin
            reg_out = ONE_HOT0 << dec_rb_s;
            y_in    = 1'b1;
          end
          default: illegal_op = 1'b1;
        endcase
      end
      T4: begin
        reg_out = ONE_HOT0 << rc_r;
        z_in    = 1'b1;
        alu_op  = OP_W'(alu_r);
      end
      T5: begin
        zlow_out = 1'b1;
`ifdef CTRL_SEQ_MULDIV_EN
        if (cls_r == CLS_MULDIV) begin
          lo_in = 1'b1;
        end else begin
          reg_in = ONE_HOT0 << ra_r;
          done   = 1'b1;
        end
`else
        reg_in = ONE_HOT0 << ra_r;
        done   = 1'b1;
`endif
      end
`ifdef CTRL_SEQ_MULDIV_EN
      T6: begin
        zhigh_out = 1'b1;
        hi_in     = 1'b1;
        done      = 1'b1;
      end
`endif
      default: busy = (state_r != IDLE);
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each instruction queues its expected per-cycle
// control word; a negedge monitor pops and compares whenever an entry is pending.
module tb_control_sequencer;

  typedef struct packed {
    logic        pc_out, mdr_out, zlow_out, zhigh_out;
    logic [15:0] reg_out, reg_in;
    logic        mar_in, pc_in, mdr_in, ir_in_en, y_in, z_in, inc_pc, read, lo_in, hi_in;
    logic [4:0]  alu_op;
    logic        busy, done, illegal_op;
  } ctl_t;

  logic        clk = 1'b0;
  logic        clr, start, mem_rdy;
  logic [31:0] ir_in;
  logic        pc_out, mdr_out, zlow_out, zhigh_out;
  logic [15:0] reg_out, reg_in;
  logic        mar_in, pc_in, mdr_in, ir_in_en, y_in, z_in, inc_pc, read, lo_in, hi_in;
  logic [4:0]  alu_op;
  logic        busy, done, illegal_op;

  int tests = 0;
  int fails = 0;
  ctl_t  sb[$];
  string sb_n[$];
  ctl_t  pend[$];
  string pend_n[$];
  ctl_t  act, exp_c;
  string exp_n;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .clr(clr), .start(start), .mem_rdy(mem_rdy), .ir_in(ir_in),
    .pc_out(pc_out), .mdr_out(mdr_out), .zlow_out(zlow_out), .zhigh_out(zhigh_out),
    .reg_out(reg_out), .reg_in(reg_in), .mar_in(mar_in), .pc_in(pc_in), .mdr_in(mdr_in),
    .ir_in_en(ir_in_en), .y_in(y_in), .z_in(z_in), .inc_pc(inc_pc), .read(read),
    .lo_in(lo_in), .hi_in(hi_in), .alu_op(alu_op), .busy(busy), .done(done),
    .illegal_op(illegal_op)
  );

  function automatic ctl_t c_idle();
    ctl_t c = '0;
    return c;
  endfunction
  function automatic ctl_t c_t0();
    ctl_t c = '0;
    c.busy = 1'b1; c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1;
    c.alu_op = 5'b11111;
    return c;
  endfunction
  function automatic ctl_t c_t1(input bit first);
    ctl_t c = '0;
    c.busy = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1; c.zlow_out = first; c.pc_in = first;
    return c;
  endfunction
  function automatic ctl_t c_t2();
    ctl_t c = '0;
    c.busy = 1'b1; c.mdr_out = 1'b1; c.ir_in_en = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_t3u(input logic [15:0] m, input logic [4:0] op);
    ctl_t c = '0;
    c.busy = 1'b1; c.reg_out = m; c.z_in = 1'b1; c.alu_op = op;
    return c;
  endfunction
  function automatic ctl_t c_t3b(input logic [15:0] m);
    ctl_t c = '0;
    c.busy = 1'b1; c.reg_out = m; c.y_in = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_t4(input logic [15:0] m, input logic [4:0] op);
    ctl_t c = '0;
    c.busy = 1'b1; c.reg_out = m; c.z_in = 1'b1; c.alu_op = op;
    return c;
  endfunction
  function automatic ctl_t c_t5(input logic [15:0] m);
    ctl_t c = '0;
    c.busy = 1'b1; c.zlow_out = 1'b1; c.reg_in = m; c.done = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_t5lo();
    ctl_t c = '0;
    c.busy = 1'b1; c.zlow_out = 1'b1; c.lo_in = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_t6();
    ctl_t c = '0;
    c.busy = 1'b1; c.zhigh_out = 1'b1; c.hi_in = 1'b1; c.done = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_ill();
    ctl_t c = '0;
    c.busy = 1'b1; c.illegal_op = 1'b1;
    return c;
  endfunction

  task automatic put(input ctl_t c, input string n);
    pend.push_back(c);
    pend_n.push_back(n);
  endtask

  // Fetch prefix: idle start cycle, T0, T1 (first + waits), T2.
  task automatic put_fetch(input string n, input int w);
    put(c_idle(), {n, "_start"});
    put(c_t0(), {n, "_T0"});
    put(c_t1(1'b1), {n, "_T1first"});
    for (int i = 0; i < w; i++) put(c_t1(1'b0), {n, "_T1wait"});
    put(c_t2(), {n, "_T2"});
  endtask

  // One instruction: staged expectations move to the scoreboard, then inputs are driven.
  task automatic run(input logic [31:0] ir, input int w, input int clr_at, input bit hold);
    int len;
    @(posedge clk); #1;
    len = pend.size();
    while (pend.size() > 0) begin
      sb.push_back(pend.pop_front());
      sb_n.push_back(pend_n.pop_front());
    end
    ir_in = ir; mem_rdy = 1'b0; start = 1'b1; clr = 1'b0;
    for (int k = 1; k < len; k++) begin
      @(posedge clk); #1;
      start   = hold && (k < len - 1);
      mem_rdy = (k >= 2 + w);
      clr     = (k == clr_at);
    end
    start = 1'b0;
    clr   = 1'b0;
  endtask

  // Monitor: compare the full control word against the oldest pending expectation.
  always @(negedge clk) begin
    act = {pc_out, mdr_out, zlow_out, zhigh_out, reg_out, reg_in, mar_in, pc_in, mdr_in,
           ir_in_en, y_in, z_in, inc_pc, read, lo_in, hi_in, alu_op, busy, done, illegal_op};
    if (sb.size() > 0) begin
      exp_c = sb.pop_front();
      exp_n = sb_n.pop_front();
      tests++;
      if (act !== exp_c) begin
        fails++;
        $display("FAIL %s: actual=%h expected=%h", exp_n, act, exp_c);
      end
    end else if (busy !== 1'b0 && clr === 1'b0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_activity: actual=%h expected=%h", act, c_idle());
    end
  end

  initial begin
    clr = 1'b1; start = 1'b0; mem_rdy = 1'b0; ir_in = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(c_idle()); sb_n.push_back("reset_a");
    sb.push_back(c_idle()); sb_n.push_back("reset_b");
    @(posedge clk); @(posedge clk); #1;
    clr = 1'b0;

    // NEG R0 <- R2 : done in cycle 5
    put_fetch("neg", 0);
    put(c_t3u(16'h0004, 5'b10000), "neg_T3");
    put(c_t5(16'h0001), "neg_T5");
    put(c_idle(), "neg_after");
    run(32'h80120000, 0, -1, 1'b0);

    // AND R5 <- R2 & R4 : done in cycle 6
    put_fetch("and", 0);
    put(c_t3b(16'h0004), "and_T3");
    put(c_t4(16'h0010, 5'b01001), "and_T4");
    put(c_t5(16'h0020), "and_T5");
    put(c_idle(), "and_after");
    run(32'h4A920000, 0, -1, 1'b0);

    // AND with three memory wait cycles : done in cycle 9
    put_fetch("andw", 3);
    put(c_t3b(16'h0004), "andw_T3");
    put(c_t4(16'h0010, 5'b01001), "andw_T4");
    put(c_t5(16'h0020), "andw_T5");
    put(c_idle(), "andw_after");
    run(32'h4A920000, 3, -1, 1'b0);

    // clr during T4 abandons the instruction
    put_fetch("clr", 0);
    put(c_t3b(16'h0004), "clr_T3");
    put(c_t4(16'h0010, 5'b01001), "clr_T4");
    put(c_idle(), "clr_idle_a");
    put(c_idle(), "clr_idle_b");
    run(32'h4A920000, 0, 5, 1'b0);

    // NOT R3 <- R7 with start held high throughout: restart ignored while busy
    put_fetch("not", 0);
    put(c_t3u(16'h0080, 5'b10001), "not_T3");
    put(c_t5(16'h0008), "not_T5");
    put(c_idle(), "not_after");
    run(32'h89B80000, 0, -1, 1'b1);

    // SUB R15 <- R15 - R0 : Ra=Rb, extreme register indices
    put_fetch("sub", 0);
    put(c_t3b(16'h8000), "sub_T3");
    put(c_t4(16'h0001, 5'b00100), "sub_T4");
    put(c_t5(16'h8000), "sub_T5");
    put(c_idle(), "sub_after");
    run(32'h27F80000, 0, -1, 1'b0);

    // Unsupported opcode 11111 with one wait cycle
    put_fetch("ill", 1);
    put(c_ill(), "ill_T3");
    put(c_idle(), "ill_after_a");
    put(c_idle(), "ill_after_b");
    run(32'hF8000000, 1, -1, 1'b0);

    // Opcode 00000 is also unsupported
    put_fetch("ill0", 0);
    put(c_ill(), "ill0_T3");
    put(c_idle(), "ill0_after");
    run(32'h00000000, 0, -1, 1'b0);

    // MUL R1 <- R4 * R4
    put_fetch("mul", 0);
`ifdef CTRL_SEQ_MULDIV_EN
    put(c_t3b(16'h0010), "mul_T3");
    put(c_t4(16'h0010, 5'b01110), "mul_T4");
    put(c_t5lo(), "mul_T5");
    put(c_t6(), "mul_T6");
    put(c_idle(), "mul_after");
`else
    put(c_ill(), "mul_T3");
    put(c_idle(), "mul_after");
`endif
    run(32'h70A20000, 0, -1, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: actual=%0d entries left, expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
